// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution layer scheduler.
package conv_pkg;

    typedef logic [31:0] float_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } sched_state_e;

    localparam float_t FP32_ZERO = 32'h0000_0000;

    function automatic int out_h(input int img_h, input int k);
        return img_h - k + 1;
    endfunction

    function automatic int out_w(input int img_w, input int k);
        return img_w - k + 1;
    endfunction

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int clogb(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_win_cnt.sv
// One level of a nested wrap counter; chain wrap_out into the next level's inc.
module conv_win_cnt #(
    parameter int W     = 1,
    parameter int LIMIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap_out
);

    // Exact-limit compare so non-power-of-two dimensions wrap correctly.
    assign wrap_out = inc && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (clr)     cnt <= '0;
        else if (wrap_out) cnt <= '0;
        else if (inc)     cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/conv_layer_sched.sv
// Convolution layer sequencer: issues taps for every (filter,row,col) window to a
// shared MAC and writes one result per window. Optional ReLU: CONV_SCHED_RELU_EN.
module conv_layer_sched
    import conv_pkg::*;
#(
    parameter int IMG_H    = 5,
    parameter int IMG_W    = 5,
    parameter int FILT_K   = 5,
    parameter int NUM_FILT = 2,
    parameter int DATA_W   = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      tap_valid,
    input  logic                                      tap_ready,
    output logic [clogb(IMG_H)-1:0]                   img_row,
    output logic [clogb(IMG_W)-1:0]                   img_col,
    output logic [clogb(NUM_FILT)-1:0]                filt_idx,
    output logic [clogb(FILT_K)-1:0]                  filt_row,
    output logic [clogb(FILT_K)-1:0]                  filt_col,
    output logic                                      acc_first,
    output logic                                      acc_last,
    input  logic                                      res_valid,
    input  logic [DATA_W-1:0]                         res_data,
    output logic                                      out_wr_en,
    output logic [clogb(NUM_FILT)-1:0]                out_filt,
    output logic [clogb(out_h(IMG_H, FILT_K))-1:0]    out_row,
    output logic [clogb(out_w(IMG_W, FILT_K))-1:0]    out_col,
    output logic [DATA_W-1:0]                         out_data,
    output logic                                      err
);

    localparam int OH  = out_h(IMG_H, FILT_K);
    localparam int OW  = out_w(IMG_W, FILT_K);
    localparam int RW  = clogb(IMG_H);
    localparam int CW  = clogb(IMG_W);
    localparam int FW  = clogb(NUM_FILT);
    localparam int KW  = clogb(FILT_K);
    localparam int ORW = clogb(OH);
    localparam int OCW = clogb(OW);

    sched_state_e      state;
    logic              clr, fire, win_adv;
    logic              kc_wrap, kr_wrap, c_wrap, r_wrap, f_wrap;
    logic [KW-1:0]     kc, kr;
    logic [OCW-1:0]    c;
    logic [ORW-1:0]    r;
    logic [FW-1:0]     f;
    logic [DATA_W-1:0] wr_data;

    assign clr     = (state == IDLE) && start;
    assign fire    = tap_valid && tap_ready;
    assign win_adv = (state == WAIT_RES) && res_valid;

    conv_win_cnt #(.W(KW),  .LIMIT(FILT_K))   u_kc (.clk, .rst_n, .clr, .inc(fire),    .cnt(kc), .wrap_out(kc_wrap));
    conv_win_cnt #(.W(KW),  .LIMIT(FILT_K))   u_kr (.clk, .rst_n, .clr, .inc(kc_wrap), .cnt(kr), .wrap_out(kr_wrap));
    conv_win_cnt #(.W(OCW), .LIMIT(OW))       u_c  (.clk, .rst_n, .clr, .inc(win_adv), .cnt(c),  .wrap_out(c_wrap));
    conv_win_cnt #(.W(ORW), .LIMIT(OH))       u_r  (.clk, .rst_n, .clr, .inc(c_wrap),  .cnt(r),  .wrap_out(r_wrap));
    conv_win_cnt #(.W(FW),  .LIMIT(NUM_FILT)) u_f  (.clk, .rst_n, .clr, .inc(r_wrap),  .cnt(f),  .wrap_out(f_wrap));

    // Tap coordinates come straight from counter registers, so they hold during stalls.
    assign img_row   = RW'(r) + RW'(kr);
    assign img_col   = CW'(c) + CW'(kc);
    assign filt_idx  = f;
    assign filt_row  = kr;
    assign filt_col  = kc;
    assign acc_first = tap_valid && (kr == '0) && (kc == '0);
    assign acc_last  = tap_valid && (kr == KW'(FILT_K - 1)) && (kc == KW'(FILT_K - 1));

    always_comb begin
`ifdef CONV_SCHED_RELU_EN
        wr_data = res_data[DATA_W-1] ? DATA_W'(FP32_ZERO) : res_data;
`else
        wr_data = res_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tap_valid <= 1'b0;
            out_wr_en <= 1'b0;
            out_filt  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            out_wr_en <= 1'b0;
            if (res_valid && state != WAIT_RES) err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state     <= ISSUE;
                    busy      <= 1'b1;
                    tap_valid <= 1'b1;
                end
                ISSUE: if (kr_wrap) begin
                    state     <= WAIT_RES;
                    tap_valid <= 1'b0;
                end
                WAIT_RES: if (res_valid) begin
                    out_wr_en <= 1'b1;
                    out_filt  <= f;
                    out_row   <= r;
                    out_col   <= c;
                    out_data  <= wr_data;
                    if (f_wrap) state <= DONE;
                    else begin
                        state     <= ISSUE;
                        tap_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Sequencer for one convolution layer built on a single shared IEEE-754 single-precision multiply-accumulate unit. Complete data set: one IMG_H x IMG_W image and NUM_FILT filters of size FILT_K x FILT_K.
- Walks every (filter, output row, output col) window and issues the FILT_K*FILT_K tap coordinates to the MAC. Collects one accumulated result per window and writes it to the output feature-map store.
- Sits between the layer-level start/done control and the image/filter memories, MAC and output buffer. Stride 1, no padding.

Parameters:
- IMG_H, 5, image rows
- IMG_W, 5, image columns
- FILT_K, 5, square filter side; must be <= IMG_H and <= IMG_W
- NUM_FILT, 2, number of filters (output channels)
- DATA_W, 32, result word width (IEEE-754 single)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  layer start request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final output write
- tap_valid  out  1  tap coordinate valid to MAC/memories
- tap_ready  in  1  MAC accepts tap this cycle
- img_row  out  $clog2(IMG_H)  image row of tap
- img_col  out  $clog2(IMG_W)  image column of tap
- filt_idx  out  $clog2(NUM_FILT) (min 1)  filter of tap
- filt_row  out  $clog2(FILT_K)  filter row of tap
- filt_col  out  $clog2(FILT_K)  filter column of tap
- acc_first  out  1  tap is first of window; MAC clears accumulator
- acc_last  out  1  tap is last of window
- res_valid  in  1  MAC window result valid
- res_data  in  DATA_W  MAC window result
- out_wr_en  out  1  output store write strobe
- out_filt  out  $clog2(NUM_FILT) (min 1)  output channel
- out_row  out  $clog2(OUT_H) (min 1)  output row, OUT_H = IMG_H-FILT_K+1
- out_col  out  $clog2(OUT_W) (min 1)  output column, OUT_W = IMG_W-FILT_K+1
- out_data  out  DATA_W  written value
- err  out  1  sticky: res_valid received outside WAIT_RES

Behaviour:
- Reset values: all outputs and internal counters 0; state IDLE.
- States:
  - IDLE: on start=1, go to ISSUE; counters f=r=c=kr=kc=0.
  - ISSUE: tap_valid=1. Coordinates are img_row=r+kr, img_col=c+kc, filt_idx=f, filt_row=kr, filt_col=kc.
    - acc_first=(kr==0&&kc==0); acc_last=(kr==FILT_K-1&&kc==FILT_K-1).
    - On tap_valid&&tap_ready: advance kc, wrapping into kr. If acc_last, go to WAIT_RES.
    - tap_ready=0 stalls with all tap outputs held stable.
  - WAIT_RES: tap_valid=0. On res_valid: register out_wr_en=1 next cycle with out_filt=f, out_row=r, out_col=c, out_data=res_data.
    - Advance c, wrapping into r, then f. Order is filter outermost, then row, then col, then kr, then kc.
    - If last window, go to DONE; else go to ISSUE with kr=kc=0.
  - DONE: done=1 for exactly one cycle (the cycle after the final out_wr_en); busy falls the same cycle; then IDLE.
- Latency: start high in IDLE at edge N gives tap_valid=1 and busy=1 after edge N. With tap_ready tied high, one window takes FILT_K^2 issue cycles plus MAC latency plus 1 cycle.
- start while busy is ignored; there is no queueing.
- res_valid outside WAIT_RES: data is discarded and err is set. err clears only on reset.
- rst_n low mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- Counters use exact-limit compares, not power-of-two wrap, so non-power-of-two dimensions are handled correctly.
- Exactly one window is outstanding at the MAC at any time.

Optional Feature:
- Macro CONV_SCHED_RELU_EN.
- Defined: out_data = 32'h0000_0000 when res_data[DATA_W-1]==1 (negative, including -0.0); otherwise res_data passes unchanged.
- Undefined: out_data = res_data unconditionally.
- No timing change either way.

Decomposition:
- conv_pkg holds: float_t (logic [31:0]); the sched_state_e enum (IDLE, ISSUE, WAIT_RES, DONE); OUT_H/OUT_W helper functions; and the FP32_ZERO constant.
- Sub-module conv_win_cnt: a parameterised nested wrap counter (limit, inc, wrap_out). It is instantiated for kc/kr and for c/r/f.

Test Plan:
- Defaults (5x5, K=5, 2 filters), tap_ready=1, MAC model latency 3 -> 50 taps, 2 windows. acc_first on taps 1 and 26, acc_last on taps 25 and 50. Writes (0,0,0) then (1,0,0). done pulse once; busy low afterwards.
- IMG 6x6, K=3, NUM_FILT=2 -> 288 taps and 32 writes in f,r,c order. Tap 10 (first of window (0,0,1)) has img_row=0, img_col=1, filt_row=0, filt_col=0.
- Random tap_ready toggling (50%) -> tap coordinates held stable while stalled. Same tap sequence and write set as with no stall.
- rst_n pulse low during window 2 of 2, then start again -> outputs 0 during reset, no done pulse. The full clean run that follows produces 2 writes and 1 done.
- res_valid asserted while in ISSUE -> err=1 and no out_wr_en; err remains set after done.
- res_data=32'hC000_0000 (-2.0) -> out_data=0 with CONV_SCHED_RELU_EN, 32'hC000_0000 without. res_data=32'h4170_0000 (15.0) passes in both builds.
